// File: rtl/uart_mmio_port_pkg.sv
// rtl/uart_mmio_port_pkg.sv - shared encodings, index defaults and FSM state types for the serial MMIO port
package uart_mmio_port_pkg;

    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [2:0] DATA_INDEX_DEF  = 3'b110;
    localparam logic [2:0] STATE_INDEX_DEF = 3'b111;

    localparam int CLKS_PER_BIT_DEF = 434;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_mmio_port_if.sv
// rtl/uart_mmio_port_if.sv - CPU-side memory-mapped access bundle for the serial port
interface uart_mmio_port_if;
    logic [1:0] memRW;
    logic [2:0] index;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [1:0] state;

    modport master (output memRW, index, wdata, input rdata, state);
    modport slave  (input memRW, index, wdata, output rdata, state);
endinterface

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - line synchroniser and 8N1 receive FSM producing a one-cycle byte strobe
module uart_rx_frame
    import uart_mmio_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic       byte_valid,
    output logic [7:0] rx_byte
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle line is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rx_line;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Frame walker: half a bit into the start bit to centre, then full-bit strides to each sample
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    state_d    = RX_IDLE;
                    byte_valid = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/uart_mmio_port.sv
// rtl/uart_mmio_port.sv - MMIO serial port top: access decode, inline 8N1 TX, RX holding register or FIFO (UART_MMIO_RX_FIFO_EN)
module uart_mmio_port
    import uart_mmio_port_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter logic [2:0] DATA_INDEX   = DATA_INDEX_DEF,
    parameter logic [2:0] STATE_INDEX  = STATE_INDEX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    uart_mmio_port_if.slave    bus,
    input  logic               u_txd,
    output logic               u_rxd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    logic          data_sel, wr_hit, rd_hit, wr_pulse, rd_pulse;
    logic          wr_hit_q, wr_hit_d, rd_hit_q, rd_hit_d;
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          rx_byte_valid, rx_valid, tx_ready;
    logic [7:0]    rx_byte;

    // The status slot wins if both indices were ever configured equal, so status reads never pop
    assign data_sel = (bus.index == DATA_INDEX) && (bus.index != STATE_INDEX);
    assign wr_hit   = (bus.memRW == MEM_WRITE) && data_sel;
    assign rd_hit   = (bus.memRW == MEM_READ) && data_sel;
    assign wr_pulse = wr_hit && !wr_hit_q;
    assign rd_pulse = rd_hit && !rd_hit_q;
    assign wr_hit_d = wr_hit;
    assign rd_hit_d = rd_hit;

    // Strobe history and transmitter state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_hit_q   <= 1'b0;
            rd_hit_q   <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            wr_hit_q   <= wr_hit_d;
            rd_hit_q   <= rd_hit_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // Transmit FSM; the line is decoded from state so reset forces it high at once
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        u_rxd      = 1'b1;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (wr_pulse) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = bus.wdata;
                end
            end
            TX_START: begin
                u_rxd = 1'b0;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                u_rxd = tx_shift_q[0];
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                u_rxd = 1'b1;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign tx_ready = (tx_state_q == TX_IDLE);

    uart_rx_frame #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_line   (u_txd),
        .byte_valid(rx_byte_valid),
        .rx_byte   (rx_byte)
    );

`ifdef UART_MMIO_RX_FIFO_EN
    logic [3:0][7:0] mem_q, mem_d;
    logic [1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]      count_q, count_d;
    logic [7:0]      last_q, last_d;
    logic            pop, push;

    // Receive FIFO storage and pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still takes a simultaneous push
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        last_d  = last_q;
        pop     = rd_pulse && (count_q != 3'd0);
        push    = rx_byte_valid && ((count_q != 3'd4) || pop);
        if (pop) begin
            last_d = mem_q[rptr_q];
            rptr_d = rptr_q + 2'd1;
        end
        if (push) begin
            mem_d[wptr_q] = rx_byte;
            wptr_d        = wptr_q + 2'd1;
        end
        count_d = count_q + {2'b00, push} - {2'b00, pop};
    end

    assign rx_valid  = (count_q != 3'd0);
    assign bus.rdata = rx_valid ? mem_q[rptr_q] : last_q;
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;

    // Single receive holding register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    // Pop is applied before delivery, so a same-cycle byte lands; otherwise an occupied register drops it
    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q;
        if (rd_pulse) valid_d = 1'b0;
        if (rx_byte_valid && (!valid_q || rd_pulse)) begin
            hold_d  = rx_byte;
            valid_d = 1'b1;
        end
    end

    assign rx_valid  = valid_q;
    assign bus.rdata = hold_q;
`endif

    assign bus.state = {rx_valid, tx_ready};

endmodule

// File: tb/tb_uart_mmio_port.sv
// tb/tb_uart_mmio_port.sv - self-checking bench for uart_mmio_port with a queue-based receive model
module tb_uart_mmio_port;
    import uart_mmio_port_pkg::*;

    localparam int CPB = 4;
`ifdef UART_MMIO_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic u_txd;
    logic u_rxd;

    uart_mmio_port_if bus();

    uart_mmio_port #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .u_txd(u_txd),
        .u_rxd(u_rxd)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] rx_q[$];
    logic [7:0] last_rd = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_deliver(input logic [7:0] b);
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
    endtask

    task automatic model_pop();
        if (rx_q.size() > 0) last_rd = rx_q.pop_front();
    endtask

    function automatic logic [7:0] exp_rdata();
        return (rx_q.size() > 0) ? rx_q[0] : last_rd;
    endfunction

    task automatic check_rx(input string tag);
        check({tag, "_rdata"}, bus.rdata, exp_rdata());
        check({tag, "_rx_valid"}, bus.state[1], rx_q.size() > 0);
    endtask

    function automatic logic line_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic send_frame(input logic [7:0] b, input int hold, input bit inject, input logic [7:0] inj);
        @(negedge clk);
        bus.memRW = MEM_WRITE;
        bus.index = DATA_INDEX_DEF;
        bus.wdata = b;
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clk);
            if (k + 1 == hold) bus.memRW = MEM_IDLE;
            if (inject && k == 3 * CPB) begin
                bus.memRW = MEM_WRITE;
                bus.wdata = inj;
            end
            if (inject && k == 3 * CPB + 2) bus.memRW = MEM_IDLE;
            check("tx_line", u_rxd, line_bit(b, k / CPB));
            check("tx_busy", bus.state[0], 1'b0);
        end
        for (int k = 0; k < 2 * CPB; k++) begin
            @(negedge clk);
            check("tx_idle_line", u_rxd, 1'b1);
            check("tx_ready", bus.state[0], 1'b1);
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        for (int i = 0; i < 10; i++) begin
            u_txd = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
            repeat (CPB) @(negedge clk);
        end
        u_txd = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] idx, input int hold);
        @(negedge clk);
        bus.memRW = MEM_READ;
        bus.index = idx;
        repeat (hold) @(negedge clk);
        bus.memRW = MEM_IDLE;
        if (idx == DATA_INDEX_DEF) model_pop();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        rst       = 1'b0;
        u_txd     = 1'b1;
        bus.memRW = MEM_IDLE;
        bus.index = 3'b000;
        bus.wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_u_rxd", u_rxd, 1'b1);
        check("rst_rdata", bus.rdata, 8'h00);
        check("rst_state", bus.state, 2'b01);
        rst = 1'b1;
        @(negedge clk);

        send_frame(8'hA5, 3, 1'b0, 8'h00);
        send_frame(8'h3C, 1, 1'b1, 8'hFF);
        b = 8'($urandom);
        send_frame(b, 2, 1'b0, 8'h00);

        rx_frame(8'h5A, 1'b1);
        model_deliver(8'h5A);
        repeat (2) @(negedge clk);
        check("rx5a_state", bus.state, 2'b11);
        check_rx("rx5a");
        cpu_read(DATA_INDEX_DEF, 2);
        check_rx("rd5a");
        cpu_read(DATA_INDEX_DEF, 1);
        check_rx("rd_empty");

        rx_frame(8'h11, 1'b1);
        model_deliver(8'h11);
        rx_frame(8'h22, 1'b1);
        model_deliver(8'h22);
        repeat (2) @(negedge clk);
        check_rx("b2b");
        for (int i = 0; i < DEPTH + 1; i++) begin
            cpu_read(DATA_INDEX_DEF, 1);
            check_rx("b2b_drain");
        end

        u_txd = 1'b0;
        @(negedge clk);
        u_txd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_rx("glitch");
        rx_frame(8'($urandom), 1'b0);
        repeat (3 * CPB) @(negedge clk);
        check_rx("framing");

        for (int n = 0; n < 8; n++) begin
            b = 8'($urandom);
            rx_frame(b, 1'b1);
            model_deliver(b);
            repeat (2) @(negedge clk);
            check_rx("rand_rx");
            if ($urandom_range(0, 2) == 0) begin
                cpu_read(DATA_INDEX_DEF, $urandom_range(1, 3));
                check_rx("rand_rd");
            end
        end

        @(negedge clk);
        bus.memRW = MEM_WRITE;
        bus.index = STATE_INDEX_DEF;
        bus.wdata = 8'h00;
        repeat (2) @(negedge clk);
        bus.memRW = MEM_IDLE;
        for (int k = 0; k < 2 * CPB; k++) begin
            @(negedge clk);
            check("stidx_line", u_rxd, 1'b1);
            check("stidx_ready", bus.state[0], 1'b1);
        end
        cpu_read(STATE_INDEX_DEF, 2);
        check_rx("stidx_read");
        for (int i = 0; i < DEPTH + 1; i++) begin
            cpu_read(DATA_INDEX_DEF, 1);
            check_rx("final_drain");
        end

        @(negedge clk);
        bus.memRW = MEM_WRITE;
        bus.index = DATA_INDEX_DEF;
        bus.wdata = 8'hC3;
        @(negedge clk);
        bus.memRW = MEM_IDLE;
        repeat (10) @(negedge clk);
        check("mid_busy", bus.state[0], 1'b0);
        rst = 1'b0;
        #1;
        rx_q.delete();
        last_rd = 8'h00;
        check("mid_rst_line", u_rxd, 1'b1);
        check("mid_rst_state", bus.state, 2'b01);
        check("mid_rst_rdata", bus.rdata, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        send_frame(8'h01, 1, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
